cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Downstream neighbour of the FU array (ALU, mult, load, branch FUs).
//  - Collects held-done results (done/value/rob_tag) from NUM_FU functional units.
//  - Grants one per cycle, round-robin.
//  - Pulses that FU's ack so it drops its done.
//  - Broadcasts the winner on the registered CDB to ROB, RS wakeup and map table.
// PARAMETERS
//  NUM_FU     4   number of requesting FUs (>=2)
//  XLEN       32  result value width
//  ROB_TAG_W  5   ROB tag width
//  SRC_W      $clog2(NUM_FU)  index width (localparam)
// PORTS
//  clock       in   1                clock
//  reset       in   1                synchronous, active-high reset
//  flush       in   1                branch-mispredict squash
//  fu_done     in   NUM_FU           per-FU result pending (held until acked)
//  fu_value    in   NUM_FU*XLEN      per-FU result value
//  fu_tag      in   NUM_FU*ROB_TAG_W per-FU destination ROB tag
//  fu_ack      out  NUM_FU           one-hot grant pulse back to FU
//  cdb_valid   out  1                broadcast valid
//  cdb_tag     out  ROB_TAG_W        broadcast ROB tag
//  cdb_value   out  XLEN             broadcast value
//  cdb_src     out  SRC_W            index of FU that produced broadcast
//  grant_cnt   out  32               total grants (CDB_PERF_CNT_EN only)
//  stall_cnt   out  32               cycles with >=1 unserved request (CDB_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: cdb_valid/cdb_tag/cdb_value/cdb_src = 0, rr_ptr = 0, counters = 0.
//    fu_ack = 0 during reset (combinational, gated by reset).
//  - Arbitration (combinational, cycle t):
//    - Search fu_done starting at rr_ptr, ascending with wrap NUM_FU-1 -> 0.
//    - First set bit wins; grant one-hot.
//    - fu_ack = grant & {NUM_FU{~flush & ~reset}}.
//  - Latency: ack in cycle t; FU clears done at edge t+1.
//    - CDB registers winner's value/tag/idx at edge t+1, cdb_valid=1 for exactly 1 cycle.
//    - FU must hold value/tag stable through cycle t (sampled same cycle as ack).
//  - Pointer: on any grant, rr_ptr <= winner+1 (wraps to 0 after NUM_FU-1).
//    - No grant: rr_ptr holds.
//  - No grant (no requests or flush): cdb_valid <= 0; tag/value/src hold last values.
//  - A given FU is never acked on consecutive cycles for one result.
//    - Its done is low the cycle after ack; a new done on the following cycle is a new result.
//  - Flush (cycle t): no ack, no broadcast at t+1.
//    - Already-registered broadcast at cycle t still visible (flush does not kill current cdb_valid).
//    - Pending FU dones are left to the FUs' own flush handling; rr_ptr holds.
//  - Reset mid-operation dominates flush and requests: outputs return to reset values next edge.
//  - Starvation bound: a held request is granted within NUM_FU cycles (absent flush).
// CONFIGURATION
//  CDB_PERF_CNT_EN defined:
//    - grant_cnt += 1 every cycle fu_ack != 0.
//    - stall_cnt += 1 every cycle where (fu_done & ~fu_ack) != 0 (includes flush cycles).
//    - Both 32-bit, wrap silently.
//  Undefined: grant_cnt/stall_cnt ports and logic removed.
// STRUCTURE
//  Shared sys_defs package: CDB_PACKET typedef (valid, rob_tag, value, src); NUM_FU, ROB_TAG_W, XLEN.
//  FU_OUT_PACKET array is the input bundle.
//  Sub-module rr_picker (NUM_FU): req, ptr -> one-hot grant + winner idx + any.
//  Pure combinational, reusable by the RS issue select.
// TESTING
//  1. Reset then FU2 done, tag=7, value=0xDEADBEEF.
//     -> fu_ack=0100 same cycle; next cycle cdb_valid=1, tag=7, value=0xDEADBEEF, src=2; rr_ptr=3.
//  2. rr_ptr=0, FU0 and FU1 done together.
//     -> ack FU0 cycle t, FU1 cycle t+1; two back-to-back broadcasts, tags in order.
//  3. All 4 FUs held done, rr_ptr=2.
//     -> ack order 2,3,0,1 over 4 cycles; cdb_valid high 4 consecutive cycles, then 0.
//  4. FU1 done with flush=1.
//     -> fu_ack=0, next cycle cdb_valid=0, rr_ptr unchanged; flush drops, FU1 granted next cycle.
//  5. Reset asserted while FU3 done and cdb_valid=1.
//     -> next cycle cdb_valid=0, src=0, rr_ptr=0, no ack during reset.
//  6. CDB_PERF_CNT_EN: 3 FUs done at once, held.
//     -> after 3 cycles grant_cnt=3, stall_cnt=2; reset clears both.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB sizes, FU/CDB packet types and pointer helper
package cdb_arbiter_pkg;

    localparam int NUM_FU    = 4;
    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 5;
    localparam int SRC_W     = $clog2(NUM_FU);

    typedef struct packed {
        logic                 done;
        logic [XLEN-1:0]      value;
        logic [ROB_TAG_W-1:0] rob_tag;
    } fu_out_packet_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      value;
        logic [SRC_W-1:0]     src;
    } cdb_packet_t;

    // Round-robin successor; explicit wrap keeps it correct for non-power-of-two NUM_FU.
    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(NUM_FU - 1)) ? '0 : idx + SRC_W'(1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rtl/cdb_arbiter_rr_picker.sv - combinational round-robin picker: req + start ptr -> one-hot grant, index, any
module cdb_arbiter_rr_picker #(
    parameter int NUM_FU = 4,
    localparam int SRC_W = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] i_req,
    input  logic [SRC_W-1:0]  i_ptr,
    output logic [NUM_FU-1:0] o_grant,
    output logic [SRC_W-1:0]  o_idx,
    output logic              o_any
);

    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            j = (int'(i_ptr) + k) % NUM_FU;
            if (!found && i_req[j]) begin
                found      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = SRC_W'(j);
            end
        end
        o_any = found;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter over NUM_FU held-done FUs; CDB_PERF_CNT_EN adds grant/stall counters
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_flush,
    input  logic [NUM_FU-1:0]           i_fu_done,
    input  logic [NUM_FU*XLEN-1:0]      i_fu_value,
    input  logic [NUM_FU*ROB_TAG_W-1:0] i_fu_tag,
    output logic [NUM_FU-1:0]           o_fu_ack,
    output logic                        o_cdb_valid,
    output logic [ROB_TAG_W-1:0]        o_cdb_tag,
    output logic [XLEN-1:0]             o_cdb_value,
    output logic [SRC_W-1:0]            o_cdb_src
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]                 o_grant_cnt,
    output logic [31:0]                 o_stall_cnt
`endif
);

    fu_out_packet_t    w_fu [NUM_FU];
    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_grant;
    logic [SRC_W-1:0]  w_idx;
    logic              w_any;
    logic              w_fire;
    logic [SRC_W-1:0]  r_rr_ptr;
    cdb_packet_t       r_cdb;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign w_fu[i].done    = i_fu_done[i];
        assign w_fu[i].value   = i_fu_value[i*XLEN +: XLEN];
        assign w_fu[i].rob_tag = i_fu_tag[i*ROB_TAG_W +: ROB_TAG_W];
        assign w_req[i]        = w_fu[i].done;
    end

    cdb_arbiter_rr_picker #(.NUM_FU(NUM_FU)) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Ack is combinational so the FU drops done at the same edge the CDB captures its result.
    assign o_fu_ack = w_grant & {NUM_FU{~i_flush & ~reset}};
    assign w_fire   = w_any & ~i_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cdb    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_cdb.valid <= w_fire;
            if (w_fire) begin
                r_cdb.rob_tag <= w_fu[w_idx].rob_tag;
                r_cdb.value   <= w_fu[w_idx].value;
                r_cdb.src     <= w_idx;
                r_rr_ptr      <= next_ptr(w_idx);
            end
        end
    end

    assign o_cdb_valid = r_cdb.valid;
    assign o_cdb_tag   = r_cdb.rob_tag;
    assign o_cdb_value = r_cdb.value;
    assign o_cdb_src   = r_cdb.src;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    // Stall counts any cycle a request is left waiting, flush cycles included.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (o_fu_ack != '0)
                r_grant_cnt <= r_grant_cnt + 32'd1;
            if ((i_fu_done & ~o_fu_ack) != '0)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_grant_cnt = r_grant_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed scoreboard bench for cdb_arbiter (counter checks under CDB_PERF_CNT_EN)
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    typedef struct {
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      val;
        logic [SRC_W-1:0]     src;
    } exp_t;

    logic                        clock = 1'b0;
    logic                        reset;
    logic                        i_flush;
    logic [NUM_FU-1:0]           i_fu_done;
    logic [NUM_FU*XLEN-1:0]      i_fu_value;
    logic [NUM_FU*ROB_TAG_W-1:0] i_fu_tag;
    logic [NUM_FU-1:0]           o_fu_ack;
    logic                        o_cdb_valid;
    logic [ROB_TAG_W-1:0]        o_cdb_tag;
    logic [XLEN-1:0]             o_cdb_value;
    logic [SRC_W-1:0]            o_cdb_src;
`ifdef CDB_PERF_CNT_EN
    logic [31:0]                 o_grant_cnt;
    logic [31:0]                 o_stall_cnt;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb [$];
    exp_t last;

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (i_flush),
        .i_fu_done   (i_fu_done),
        .i_fu_value  (i_fu_value),
        .i_fu_tag    (i_fu_tag),
        .o_fu_ack    (o_fu_ack),
        .o_cdb_valid (o_cdb_valid),
        .o_cdb_tag   (o_cdb_tag),
        .o_cdb_value (o_cdb_value),
        .o_cdb_src   (o_cdb_src)
`ifdef CDB_PERF_CNT_EN
        ,
        .o_grant_cnt (o_grant_cnt),
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [NUM_FU-1:0] oh);
        int r = 0;
        for (int i = 0; i < NUM_FU; i++)
            if (oh[i]) r = i;
        return r;
    endfunction

    task automatic set_fu(input int i, input logic [ROB_TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        i_fu_tag[i*ROB_TAG_W +: ROB_TAG_W] = tag;
        i_fu_value[i*XLEN +: XLEN]         = val;
        i_fu_done[i]                       = 1'b1;
    endtask

    // One arbitration cycle: check ack mid-cycle, model the FU clearing done, check the CDB after the edge.
    task automatic step(input logic [NUM_FU-1:0] exp_ack, input string name);
        int   idx;
        exp_t e;
        @(negedge clock);
        chk({name, "_ack"}, 64'(o_fu_ack), 64'(exp_ack));
        if (exp_ack != '0) begin
            idx   = oh2idx(exp_ack);
            e.tag = i_fu_tag[idx*ROB_TAG_W +: ROB_TAG_W];
            e.val = i_fu_value[idx*XLEN +: XLEN];
            e.src = SRC_W'(idx);
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        i_fu_done = i_fu_done & ~exp_ack;
        chk({name, "_valid"}, 64'(o_cdb_valid), 64'(exp_ack != '0));
        if (exp_ack != '0) begin
            if (sb.size() > 0) begin
                last = sb.pop_front();
            end
        end
        chk({name, "_tag"}, 64'(o_cdb_tag), 64'(last.tag));
        chk({name, "_value"}, 64'(o_cdb_value), 64'(last.val));
        chk({name, "_src"}, 64'(o_cdb_src), 64'(last.src));
    endtask

    initial begin
        last       = '{tag: '0, val: '0, src: '0};
        reset      = 1'b1;
        i_flush    = 1'b0;
        i_fu_done  = 4'b1000;
        i_fu_value = '0;
        i_fu_tag   = '0;

        // Reset state; a pending request must not be acked while reset is high.
        @(negedge clock);
        chk("rst_ack", 64'(o_fu_ack), 64'h0);
        @(posedge clock);
        #1;
        chk("rst_valid", 64'(o_cdb_valid), 64'h0);
        chk("rst_tag", 64'(o_cdb_tag), 64'h0);
        chk("rst_value", 64'(o_cdb_value), 64'h0);
        chk("rst_src", 64'(o_cdb_src), 64'h0);
        chk("rst_ptr", 64'(dut.r_rr_ptr), 64'h0);
        reset     = 1'b0;
        i_fu_done = '0;

        // Single request from FU2.
        set_fu(2, 5'd7, 32'hDEADBEEF);
        step(4'b0100, "t1");
        chk("t1_ptr", 64'(dut.r_rr_ptr), 64'd3);
        step(4'b0000, "t1_idle");

        // Move pointer to 0 through FU3, then FU0/FU1 together.
        set_fu(3, 5'd12, 32'h3333_0003);
        step(4'b1000, "t2_pre");
        chk("t2_ptr0", 64'(dut.r_rr_ptr), 64'd0);
        set_fu(0, 5'd1, 32'h1111_0000);
        set_fu(1, 5'd2, 32'h2222_0001);
        step(4'b0001, "t2_a");
        step(4'b0010, "t2_b");
        chk("t2_ptr", 64'(dut.r_rr_ptr), 64'd2);

        // All four held, pointer at 2.
        set_fu(0, 5'd20, 32'hA0A0_0000);
        set_fu(1, 5'd21, 32'hA1A1_0001);
        set_fu(2, 5'd22, 32'hA2A2_0002);
        set_fu(3, 5'd23, 32'hA3A3_0003);
        step(4'b0100, "t3_0");
        step(4'b1000, "t3_1");
        step(4'b0001, "t3_2");
        step(4'b0010, "t3_3");
        step(4'b0000, "t3_idle");
        chk("t3_ptr", 64'(dut.r_rr_ptr), 64'd2);

        // Flush suppresses ack and broadcast, pointer holds.
        set_fu(1, 5'd9, 32'h0000_BEEF);
        i_flush = 1'b1;
        step(4'b0000, "t4_flush");
        chk("t4_ptr_hold", 64'(dut.r_rr_ptr), 64'd2);
        i_flush = 1'b0;
        step(4'b0010, "t4_after");

        // Flush does not kill a broadcast already on the CDB.
        set_fu(0, 5'd4, 32'h0404_0404);
        i_flush = 1'b1;
        @(negedge clock);
        chk("t4_cdb_live", 64'(o_cdb_valid), 64'd1);
        step(4'b0000, "t4_flush2");
        i_flush = 1'b0;
        step(4'b0001, "t4_fu0");
        chk("t4_ptr", 64'(dut.r_rr_ptr), 64'd1);

        // Reset mid-operation with FU3 pending and a live broadcast.
        set_fu(3, 5'd30, 32'h3030_3030);
        step(4'b1000, "t5_pre");
        i_fu_done[3] = 1'b1;
        reset        = 1'b1;
        @(negedge clock);
        chk("t5_ack", 64'(o_fu_ack), 64'h0);
        chk("t5_live", 64'(o_cdb_valid), 64'd1);
        @(posedge clock);
        #1;
        chk("t5_valid", 64'(o_cdb_valid), 64'h0);
        chk("t5_src", 64'(o_cdb_src), 64'h0);
        chk("t5_tag", 64'(o_cdb_tag), 64'h0);
        chk("t5_ptr", 64'(dut.r_rr_ptr), 64'h0);
`ifdef CDB_PERF_CNT_EN
        chk("t5_gcnt", 64'(o_grant_cnt), 64'h0);
        chk("t5_scnt", 64'(o_stall_cnt), 64'h0);
`endif
        reset     = 1'b0;
        i_fu_done = '0;
        sb.delete();
        last = '{tag: '0, val: '0, src: '0};

        // Three held requests: 3 grants, 2 stall cycles.
        set_fu(0, 5'd10, 32'h0000_0010);
        set_fu(1, 5'd11, 32'h0000_0011);
        set_fu(2, 5'd13, 32'h0000_0013);
        step(4'b0001, "t6_0");
        step(4'b0010, "t6_1");
        step(4'b0100, "t6_2");
`ifdef CDB_PERF_CNT_EN
        chk("t6_gcnt", 64'(o_grant_cnt), 64'd3);
        chk("t6_scnt", 64'(o_stall_cnt), 64'd2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("t6_gcnt_rst", 64'(o_grant_cnt), 64'h0);
        chk("t6_scnt_rst", 64'(o_stall_cnt), 64'h0);
`endif
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
